// File: rtl/branch_update_queue_if.sv
// branch_update_queue_if: prediction/resolution/update bundle between a branch predictor and its update queue
// master: prediction and resolution source (drives pred_*, res_*, flush)
// slave : branch_update_queue (drives ready flags, update record, occupancy, statistics)
interface branch_update_queue_if #(
    parameter int IP_W  = 64,
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
);
    localparam int OW = $clog2(DEPTH) + 1;
    logic            pred_valid;
    logic [IP_W-1:0] pred_ip;
    logic            pred_taken;
    logic            pred_ready;
    logic            res_valid;
    logic            res_taken;
    logic            res_ready;
    logic            flush;
    logic            upd_valid;
    logic [IP_W-1:0] upd_ip;
    logic            upd_taken;
    logic            upd_mispredict;
    logic [OW-1:0]   occupancy;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispredict_cnt;
    modport master (
        output pred_valid, pred_ip, pred_taken, res_valid, res_taken, flush,
        input  pred_ready, res_ready, upd_valid, upd_ip, upd_taken, upd_mispredict,
               occupancy, branch_cnt, mispredict_cnt
    );
    modport slave (
        input  pred_valid, pred_ip, pred_taken, res_valid, res_taken, flush,
        output pred_ready, res_ready, upd_valid, upd_ip, upd_taken, upd_mispredict,
               occupancy, branch_cnt, mispredict_cnt
    );
endinterface

// File: rtl/branch_update_queue.sv
// branch_update_queue: in-order FIFO of issued predictions that emits registered predictor update records on resolution
// Ports: clk, reset_n (async active-low), bus (branch_update_queue_if.slave):
//   pred_valid/pred_ip/pred_taken/pred_ready push side, res_valid/res_taken/res_ready pop side,
//   flush, upd_* update record, occupancy, branch_cnt/mispredict_cnt.
// Macro BRANCH_UPDATE_QUEUE_STATS_EN builds the saturating statistics counters; otherwise they read 0.
module branch_update_queue #(
    parameter int IP_W  = 64,
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input logic                 clk,
    input logic                 reset_n,
    branch_update_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    logic [IP_W-1:0] ip_mem [DEPTH];
    logic [DEPTH-1:0] tk_mem;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] occ;
    logic push, pop, mis;
    assign bus.pred_ready = occ != (AW+1)'(DEPTH);
    assign bus.res_ready  = occ != '0;
    assign bus.occupancy  = occ;
    // flush wins over both sides, so neither a push nor a pop is accepted in its cycle
    assign push = bus.pred_valid && bus.pred_ready && !bus.flush;
    assign pop  = bus.res_valid && bus.res_ready && !bus.flush;
    assign mis  = tk_mem[rd_ptr] ^ bus.res_taken;
    always_ff @(posedge clk) begin
        if (push) begin
            ip_mem[wr_ptr] <= bus.pred_ip;
            tk_mem[wr_ptr] <= bus.pred_taken;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            occ    <= occ + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.upd_valid      <= 1'b0;
            bus.upd_ip         <= '0;
            bus.upd_taken      <= 1'b0;
            bus.upd_mispredict <= 1'b0;
        end else begin
            bus.upd_valid <= pop;
            if (pop) begin
                bus.upd_ip         <= ip_mem[rd_ptr];
                bus.upd_taken      <= bus.res_taken;
                bus.upd_mispredict <= mis;
            end
        end
    end
`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
    logic [CNT_W-1:0] b_cnt, m_cnt;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            b_cnt <= '0;
            m_cnt <= '0;
        end else begin
            b_cnt <= (pop && !(&b_cnt)) ? b_cnt + 1'b1 : b_cnt;
            m_cnt <= (pop && mis && !(&m_cnt)) ? m_cnt + 1'b1 : m_cnt;
        end
    end
    assign bus.branch_cnt     = b_cnt;
    assign bus.mispredict_cnt = m_cnt;
`else
    assign bus.branch_cnt     = {CNT_W{1'b0}};
    assign bus.mispredict_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_branch_update_queue.sv
// tb_branch_update_queue: directed self-checking bench for branch_update_queue (DEPTH=8, CNT_W=4)
module tb_branch_update_queue;
    localparam int IP_W = 64;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int failures = 0;
    branch_update_queue_if #(.IP_W(IP_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();
    branch_update_queue #(.IP_W(IP_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [63:0] cexp(input int n);
        return STATS ? 64'(n > 15 ? 15 : n) : 64'd0;
    endfunction
    task automatic pulse_reset();
        #2 reset_n = 1'b0;
        #1 reset_n = 1'b1;
    endtask
    initial begin
        bus.pred_valid = 0; bus.pred_ip = '0; bus.pred_taken = 0;
        bus.res_valid = 0; bus.res_taken = 0; bus.flush = 0;
        repeat (2) tick();
        reset_n = 1'b1;
        chk("init_occ", 64'(bus.occupancy), 64'd0);
        chk("init_pred_ready", 64'(bus.pred_ready), 64'd1);
        chk("init_res_ready", 64'(bus.res_ready), 64'd0);
        // three entries queued, then asynchronous reset mid-cycle
        bus.pred_valid = 1;
        for (int i = 0; i < 3; i++) begin
            bus.pred_ip = 64'hA0 + 64'(i);
            tick();
        end
        bus.pred_valid = 0;
        chk("q3_occ", 64'(bus.occupancy), 64'd3);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_occ", 64'(bus.occupancy), 64'd0);
        chk("rst_pred_ready", 64'(bus.pred_ready), 64'd1);
        chk("rst_res_ready", 64'(bus.res_ready), 64'd0);
        chk("rst_upd_valid", 64'(bus.upd_valid), 64'd0);
        chk("rst_bcnt", 64'(bus.branch_cnt), 64'd0);
        chk("rst_mcnt", 64'(bus.mispredict_cnt), 64'd0);
        reset_n = 1'b1;
        tick();
        // single mispredicted branch
        bus.pred_valid = 1; bus.pred_ip = 64'h400100; bus.pred_taken = 1;
        tick();
        bus.pred_valid = 0;
        bus.res_valid = 1; bus.res_taken = 0;
        tick();
        bus.res_valid = 0;
        chk("one_upd_valid", 64'(bus.upd_valid), 64'd1);
        chk("one_upd_ip", bus.upd_ip, 64'h400100);
        chk("one_upd_taken", 64'(bus.upd_taken), 64'd0);
        chk("one_upd_mis", 64'(bus.upd_mispredict), 64'd1);
        chk("one_bcnt", 64'(bus.branch_cnt), cexp(1));
        chk("one_mcnt", 64'(bus.mispredict_cnt), cexp(1));
        tick();
        chk("one_upd_pulse", 64'(bus.upd_valid), 64'd0);
        chk("one_upd_ip_hold", bus.upd_ip, 64'h400100);
        chk("one_upd_mis_hold", 64'(bus.upd_mispredict), 64'd1);
        // fill to full, reject a ninth push, then drain in order (pointers wrap)
        bus.pred_valid = 1;
        for (int i = 0; i < 8; i++) begin
            bus.pred_ip = 64'h10 + 64'(i); bus.pred_taken = 1'(i);
            tick();
        end
        chk("full_occ", 64'(bus.occupancy), 64'd8);
        chk("full_pred_ready", 64'(bus.pred_ready), 64'd0);
        bus.pred_ip = 64'h18; bus.pred_taken = 0;
        tick();
        bus.pred_valid = 0;
        chk("full_push_ignored", 64'(bus.occupancy), 64'd8);
        bus.res_valid = 1;
        for (int i = 0; i < 8; i++) begin
            bus.res_taken = 1'(i);
            tick();
            chk($sformatf("drain_valid%0d", i), 64'(bus.upd_valid), 64'd1);
            chk($sformatf("drain_ip%0d", i), bus.upd_ip, 64'h10 + 64'(i));
            chk($sformatf("drain_mis%0d", i), 64'(bus.upd_mispredict), 64'd0);
        end
        bus.res_valid = 0;
        chk("drain_occ", 64'(bus.occupancy), 64'd0);
        chk("drain_bcnt", 64'(bus.branch_cnt), cexp(9));
        chk("drain_mcnt", 64'(bus.mispredict_cnt), cexp(1));
        tick();
        chk("drain_no_ip18", 64'(bus.upd_valid), 64'd0);
        // clear counters, then simultaneous push/pop at full
        pulse_reset();
        tick();
        bus.pred_valid = 1; bus.pred_taken = 0;
        for (int i = 0; i < 8; i++) begin
            bus.pred_ip = 64'h20 + 64'(i);
            tick();
        end
        bus.pred_ip = 64'h28;
        bus.res_valid = 1; bus.res_taken = 0;
        tick();
        bus.res_valid = 0;
        chk("pp_full_occ", 64'(bus.occupancy), 64'd7);
        chk("pp_full_upd_ip", bus.upd_ip, 64'h20);
        chk("pp_full_pred_ready", 64'(bus.pred_ready), 64'd1);
        tick();
        bus.pred_valid = 0;
        chk("pp_refill_occ", 64'(bus.occupancy), 64'd8);
        bus.res_valid = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("wrap_ip%0d", i), bus.upd_ip, 64'h21 + 64'(i));
            chk($sformatf("wrap_valid%0d", i), 64'(bus.upd_valid), 64'd1);
        end
        chk("wrap_bcnt", 64'(bus.branch_cnt), cexp(9));
        chk("wrap_mcnt", 64'(bus.mispredict_cnt), cexp(0));
        // resolution while empty is ignored
        bus.res_taken = 1;
        tick();
        bus.res_valid = 0;
        chk("empty_res_upd", 64'(bus.upd_valid), 64'd0);
        chk("empty_res_bcnt", 64'(bus.branch_cnt), cexp(9));
        chk("empty_res_occ", 64'(bus.occupancy), 64'd0);
        // flush with 5 entries plus a concurrent push and resolution
        bus.pred_valid = 1; bus.pred_taken = 0;
        for (int i = 0; i < 5; i++) begin
            bus.pred_ip = 64'h30 + 64'(i);
            tick();
        end
        chk("pre_flush_occ", 64'(bus.occupancy), 64'd5);
        bus.pred_ip = 64'h35; bus.flush = 1; bus.res_valid = 1; bus.res_taken = 1;
        tick();
        bus.flush = 0; bus.pred_valid = 0; bus.res_valid = 0;
        chk("flush_occ", 64'(bus.occupancy), 64'd0);
        chk("flush_upd_valid", 64'(bus.upd_valid), 64'd0);
        chk("flush_res_ready", 64'(bus.res_ready), 64'd0);
        chk("flush_bcnt", 64'(bus.branch_cnt), cexp(9));
        chk("flush_mcnt", 64'(bus.mispredict_cnt), cexp(0));
        bus.pred_valid = 1; bus.pred_ip = 64'h40; bus.pred_taken = 1;
        tick();
        bus.pred_valid = 0; bus.res_valid = 1; bus.res_taken = 1;
        tick();
        bus.res_valid = 0;
        chk("post_flush_ip", bus.upd_ip, 64'h40);
        chk("post_flush_mis", 64'(bus.upd_mispredict), 64'd0);
        chk("post_flush_taken", 64'(bus.upd_taken), 64'd1);
        // saturation: 20 mispredicted resolutions
        pulse_reset();
        tick();
        for (int i = 0; i < 20; i++) begin
            bus.pred_valid = 1; bus.pred_ip = 64'h50 + 64'(i); bus.pred_taken = 1;
            tick();
            bus.pred_valid = 0; bus.res_valid = 1; bus.res_taken = 0;
            tick();
            bus.res_valid = 0;
            if (i == 13) begin
                chk("sat_bcnt14", 64'(bus.branch_cnt), cexp(14));
                chk("sat_mcnt14", 64'(bus.mispredict_cnt), cexp(14));
            end
        end
        chk("sat_bcnt", 64'(bus.branch_cnt), cexp(20));
        chk("sat_mcnt", 64'(bus.mispredict_cnt), cexp(20));
        chk("sat_last_ip", bus.upd_ip, 64'h63);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
